hc_add_arbiter: RTL and testbench

HC_ADD_ARBITER -- requirements
Module: hc_add_arbiter

---
 rtl/hc_add_arbiter.sv | 143 ++++++++++++++
 tb/tb_hc_add_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hc_add_arbiter.sv
// Round-robin arbiter feeding one Han-Carlson adder; serves a single operation at a time.
// Latency: rsp_valid rises 3 cycles after the acceptance cycle (IDLE -> OPND -> CALC -> RESP).
// Backpressure: the response is held in RESP until rsp_ready; no request is accepted meanwhile.
module hc_add_arbiter #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*WIDTH-1:0]    req_a,
    input  logic [NREQ*WIDTH-1:0]    req_b,
    input  logic [NREQ-1:0]          req_cin,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic                     rsp_cout,
    output logic [15:0]              ops_done
);
    localparam int IW = $clog2(NREQ);
    localparam int N  = WIDTH + 1;
    localparam int LV = $clog2(N);

    typedef enum logic [1:0] {IDLE, OPND, CALC, RESP} state_t;

    state_t            state, state_nxt;
    logic [IW-1:0]     rr_ptr, gnt_idx, id_r;
    logic              gnt_vld, accept;
    logic [WIDTH-1:0]  a_r, b_r;
    logic              cin_r;
    logic [N-1:0]      g_r, p_r, gi;

    // Lowest offset from rr_ptr wins; scanning downward lets the last hit be the winner.
    always_comb begin
        int            j;
        logic [IW-1:0] idx;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        j       = 0;
        idx     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = int'(rr_ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            idx = IW'(j);
            if (req_valid[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (rst_n && state == IDLE && gnt_vld) req_ready[gnt_idx] = 1'b1;
    end

    assign accept    = (state == IDLE) && gnt_vld;
    assign rsp_valid = (state == RESP);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = OPND;
            OPND:    state_nxt = CALC;
            CALC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Han-Carlson: pair odd bits, Kogge-Stone over odd bits, then fix up even bits.
    always_comb begin
        logic [N-1:0] gl [0:LV+1];
        logic [N-1:0] pl [0:LV+1];
        for (int l = 0; l <= LV + 1; l++) begin
            gl[l] = '0;
            pl[l] = '0;
        end
        gl[0] = g_r;
        pl[0] = p_r;
        gl[1] = gl[0];
        pl[1] = pl[0];
        for (int i = 1; i < N; i += 2) begin
            gl[1][i] = gl[0][i] | (pl[0][i] & gl[0][i-1]);
            pl[1][i] = pl[0][i] & pl[0][i-1];
        end
        for (int l = 1; l < LV; l++) begin
            gl[l+1] = gl[l];
            pl[l+1] = pl[l];
            for (int i = 1; i < N; i += 2) begin
                if (i > (1 << l)) begin
                    gl[l+1][i] = gl[l][i] | (pl[l][i] & gl[l][i-(1 << l)]);
                    pl[l+1][i] = pl[l][i] & pl[l][i-(1 << l)];
                end
            end
        end
        gl[LV+1] = gl[LV];
        pl[LV+1] = pl[LV];
        for (int i = 2; i < N; i += 2) begin
            gl[LV+1][i] = gl[LV][i] | (pl[LV][i] & gl[LV][i-1]);
            pl[LV+1][i] = pl[LV][i] & pl[LV][i-1];
        end
        gi = gl[LV+1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            a_r      <= '0;
            b_r      <= '0;
            cin_r    <= 1'b0;
            id_r     <= '0;
            g_r      <= '0;
            p_r      <= '0;
            rsp_id   <= '0;
            rsp_sum  <= '0;
            rsp_cout <= 1'b0;
            ops_done <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                a_r    <= req_a[gnt_idx*WIDTH +: WIDTH];
                b_r    <= req_b[gnt_idx*WIDTH +: WIDTH];
                cin_r  <= req_cin[gnt_idx];
                id_r   <= gnt_idx;
                rr_ptr <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
            end
            if (state == OPND) begin
                g_r <= {a_r & b_r, cin_r};
                p_r <= {a_r ^ b_r, 1'b0};
            end
            if (state == CALC) begin
                rsp_sum  <= p_r[N-1:1] ^ gi[N-2:0];
                rsp_cout <= gi[N-1];
                rsp_id   <= id_r;
            end
            if (state == RESP && rsp_ready) ops_done <= ops_done + 16'd1;
        end
    end
endmodule

// File: tb/tb_hc_add_arbiter.sv
// Randomized and directed bench for hc_add_arbiter against a transaction-level reference model.
module tb_hc_add_arbiter;
    localparam int WIDTH = 16;
    localparam int NREQ  = 4;
    localparam int IW    = 2;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b1;
    logic [NREQ-1:0]        req_valid = '0, req_ready, req_cin = '0;
    logic [NREQ*WIDTH-1:0]  req_a = '0, req_b = '0;
    logic                   rsp_valid, rsp_ready = 1'b0, rsp_cout;
    logic [IW-1:0]          rsp_id;
    logic [WIDTH-1:0]       rsp_sum;
    logic [15:0]            ops_done;

    always #5 clk = ~clk;

    hc_add_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
        .ops_done(ops_done)
    );

    int errs = 0, checks = 0;

    // reference model: one outstanding transaction, age counted in cycles since acceptance
    bit m_pend = 0;
    int m_age = 0, m_ptr = 0, m_done = 0, m_accepts = 0;
    int m_id = 0, m_sum = 0, m_cout = 0;
    int last_gnt = -1;
    int wait_cnt [NREQ];
    int max_wait = 0;
    int gnt_log [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int ref_grant(input logic [NREQ-1:0] v, input int ptr);
        for (int k = 0; k < NREQ; k++)
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        return -1;
    endfunction

    task automatic model_reset();
        m_pend = 0; m_age = 0; m_ptr = 0; m_done = 0; last_gnt = -1;
        for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
    endtask

    task automatic drive(input logic [NREQ-1:0] v, input logic [NREQ*WIDTH-1:0] a,
                         input logic [NREQ*WIDTH-1:0] b, input logic [NREQ-1:0] c, input logic rr);
        req_valid = v; req_a = a; req_b = b; req_cin = c; rsp_ready = rr;
        #1;
    endtask

    task automatic check_cycle();
        int g;
        logic [NREQ-1:0] exp_rdy;
        bit exp_rv;
        g = m_pend ? -1 : ref_grant(req_valid, m_ptr);
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        exp_rv = m_pend && (m_age >= 3);
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        if (exp_rv) begin
            chk("rsp_id", 32'(rsp_id), m_id);
            chk("rsp_sum", 32'(rsp_sum), m_sum);
            chk("rsp_cout", 32'(rsp_cout), m_cout);
        end
        chk("ops_done", 32'(ops_done), m_done & 32'hFFFF);
        last_gnt = g;
    endtask

    task automatic adv();
        int a, b, tot;
        @(posedge clk);
        if (last_gnt >= 0) begin
            a = int'(req_a[last_gnt*WIDTH +: WIDTH]);
            b = int'(req_b[last_gnt*WIDTH +: WIDTH]);
            tot = a + b + int'(req_cin[last_gnt]);
            m_sum = tot & 32'hFFFF; m_cout = tot >> WIDTH; m_id = last_gnt;
            m_pend = 1; m_age = 1; m_ptr = (last_gnt + 1) % NREQ; m_accepts++;
            gnt_log.push_back(last_gnt);
            for (int i = 0; i < NREQ; i++) begin
                if (i == last_gnt) wait_cnt[i] = 0;
                else if (req_valid[i]) begin
                    wait_cnt[i]++;
                    if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
                end else wait_cnt[i] = 0;
            end
        end else if (m_pend) begin
            if (m_age >= 3 && rsp_ready) begin
                m_pend = 0; m_done++;
            end else if (m_age < 3) m_age++;
        end
        @(negedge clk);
    endtask

    task automatic step(input logic [NREQ-1:0] v, input logic rr);
        drive(v, {$urandom, $urandom}, {$urandom, $urandom}, NREQ'($urandom), rr);
        check_cycle();
        adv();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive('1, {$urandom, $urandom}, {$urandom, $urandom}, '1, 1'b1);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_id", 32'(rsp_id), 0);
        chk("rst_rsp_sum", 32'(rsp_sum), 0);
        chk("rst_rsp_cout", 32'(rsp_cout), 0);
        chk("rst_ops_done", 32'(ops_done), 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic run_op(input int idx, input logic [15:0] a, input logic [15:0] b, input logic c,
                          input logic [15:0] es, input logic ec, input string tag);
        logic [NREQ*WIDTH-1:0] av, bv;
        logic [NREQ-1:0] v, cv;
        int lat;
        bit seen;
        av = {$urandom, $urandom}; bv = {$urandom, $urandom}; cv = NREQ'($urandom);
        av[idx*WIDTH +: WIDTH] = a; bv[idx*WIDTH +: WIDTH] = b; cv[idx] = c;
        v = '0; v[idx] = 1'b1;
        drive(v, av, bv, cv, 1'b0);
        check_cycle();
        chk({tag, "_gnt"}, 32'(req_ready), 32'(v));
        adv();
        lat = 1; seen = 0;
        while (!seen && lat < 10) begin
            drive('0, {$urandom, $urandom}, {$urandom, $urandom}, NREQ'($urandom), 1'b0);
            check_cycle();
            if (rsp_valid) begin
                seen = 1;
                chk({tag, "_latency"}, lat, 3);
                chk({tag, "_id"}, 32'(rsp_id), idx);
                chk({tag, "_sum"}, 32'(rsp_sum), 32'(es));
                chk({tag, "_cout"}, 32'(rsp_cout), 32'(ec));
            end
            adv();
            lat++;
        end
        if (!seen) chk({tag, "_timeout"}, 0, 1);
        step('0, 1'b1);
    endtask

    initial begin
        #100_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] csum, cid, ccout, cdone;
        int n, start, cyc;
        model_reset();
        #2;
        @(negedge clk);
        do_reset();

        // single op, requester 2, full carry ripple to cout
        run_op(2, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, "single");

        // all requesters valid, round-robin order
        do_reset();
        gnt_log.delete();
        n = 0;
        while (m_done < 5 && n < 60) begin
            step('1, 1'b1);
            n++;
        end
        chk("rr_grants", gnt_log.size(), 5);
        if (gnt_log.size() >= 5) begin
            chk("rr_g0", gnt_log[0], 0);
            chk("rr_g1", gnt_log[1], 1);
            chk("rr_g2", gnt_log[2], 2);
            chk("rr_g3", gnt_log[3], 3);
            chk("rr_g4", gnt_log[4], 0);
        end
        chk("rr_ops_done", 32'(ops_done), 5);

        // backpressure: response must hold for 10 stalled cycles
        step(4'b0001, 1'b0);
        n = 0;
        while (!rsp_valid && n < 10) begin
            step('1, 1'b0);
            n++;
        end
        chk("bp_resp", 32'(rsp_valid), 1);
        csum = 32'(rsp_sum); cid = 32'(rsp_id); ccout = 32'(rsp_cout); cdone = 32'(ops_done);
        for (int i = 0; i < 10; i++) begin
            drive('1, {$urandom, $urandom}, {$urandom, $urandom}, '1, 1'b0);
            check_cycle();
            chk("bp_sum", 32'(rsp_sum), csum);
            chk("bp_id", 32'(rsp_id), cid);
            chk("bp_cout", 32'(rsp_cout), ccout);
            chk("bp_ready", 32'(req_ready), 0);
            chk("bp_done", 32'(ops_done), cdone);
            adv();
        end
        step('0, 1'b1);
        chk("bp_done_inc", 32'(ops_done), cdone + 1);

        run_op(1, 16'h7FFF, 16'h7FFF, 1'b1, 16'hFFFF, 1'b0, "carry");

        // reset during CALC discards the operation
        step(4'b0010, 1'b0);
        step('0, 1'b0);
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive('0, '0, '0, '0, 1'b1);
            check_cycle();
            chk("rst_no_rsp", 32'(rsp_valid), 0);
            adv();
        end
        drive(4'b1001, {$urandom, $urandom}, {$urandom, $urandom}, '0, 1'b1);
        check_cycle();
        chk("rst_first_gnt", 32'(req_ready), 32'(4'b0001));
        adv();
        n = 0;
        while (m_pend && n < 10) begin
            step('0, 1'b1);
            n++;
        end
        chk("rst_drain", 32'(m_pend), 0);

        // random sweep
        max_wait = 0;
        for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
        start = m_accepts;
        cyc = 0;
        while (m_accepts - start < 10000 && cyc < 80000) begin
            step(NREQ'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
            cyc++;
        end
        chk("sweep_ops", m_accepts - start, 10000);
        chk("sweep_fair", 32'(max_wait <= NREQ - 1), 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
